// File: rtl/led_pwm_pkg.sv
// led_pwm_pkg
//   Shared definitions for the LED PWM sequencer:
//   - state_t        : sequencer FSM states (encoding is visible in STATUS[1:0])
//   - ADDR_*         : Avalon-MM word addresses of the register map
//   - CTRL_*_BIT     : bit positions inside the CTRL register
//   - eff_periods()  : maps a zero period count to one
package led_pwm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_HOLD = 2'd2,
        ST_DOWN = 2'd3
    } state_t;

    localparam logic [2:0] ADDR_CTRL     = 3'd0;
    localparam logic [2:0] ADDR_MASK     = 3'd1;
    localparam logic [2:0] ADDR_PRESCALE = 3'd2;
    localparam logic [2:0] ADDR_DUTY     = 3'd3;
    localparam logic [2:0] ADDR_FADE     = 3'd4;
    localparam logic [2:0] ADDR_STATUS   = 3'd5;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_BIT = 1;

    // A programmed count of 0 behaves like 1 so the fade never stalls.
    function automatic logic [7:0] eff_periods(input logic [7:0] n);
        return (n == 8'd0) ? 8'd1 : n;
    endfunction

endpackage

// File: rtl/led_pwm_timebase.sv
// led_pwm_timebase
//   Prescaler plus free-running PWM counter.
//   Ports:
//     clk, reset_n   : clock, asynchronous active-low reset
//     enable         : when low, both counters are held at zero
//     prescale       : tick period is prescale+1 cycles
//     tick           : one-cycle strobe advancing the PWM counter
//     pwm_cnt        : PWM counter, wraps from all-ones to zero
//     period_end     : tick while pwm_cnt is all-ones (last tick of a period)
module led_pwm_timebase #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [15:0]         prescale,
    output logic                tick,
    output logic [PWM_BITS-1:0] pwm_cnt,
    output logic                period_end
);

    logic [15:0] presc_cnt;

    // ">=" rather than "==" so lowering PRESCALE below the running count
    // ticks immediately instead of wrapping through 65535.
    assign tick       = enable && (presc_cnt >= prescale);
    assign period_end = tick && (pwm_cnt == '1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
        end else if (!enable) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
        end else if (tick) begin
            presc_cnt <= '0;
            pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
        end else begin
            presc_cnt <= presc_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/led_pwm_sequencer.sv
// led_pwm_sequencer
//   Avalon-MM controlled PWM driver for N_LED LEDs with static or
//   triangular fade brightness.
//   Ports:
//     clk, reset_n   : clock, asynchronous active-low reset
//     address        : register word address (0..7)
//     chipselect     : bus select
//     write_n        : active-low write strobe
//     writedata      : write data
//     readdata       : combinational read data, zero wait states
//     out_port       : registered PWM drive, one bit per LED
module led_pwm_sequencer
    import led_pwm_pkg::*;
#(
    parameter int N_LED    = 26,
    parameter int PWM_BITS = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [N_LED-1:0]  out_port
);

    logic                ctrl_en;
    logic                ctrl_mode;
    logic [N_LED-1:0]    mask;
    logic [15:0]         prescale;
    logic [PWM_BITS-1:0] duty;
    logic [7:0]          step_periods;
    logic [7:0]          hold_periods;
    logic                wr_en;

    logic                tick;
    logic                period_end;
    logic [PWM_BITS-1:0] pwm_cnt;

    state_t              state, state_nx;
    logic [PWM_BITS-1:0] cur_duty, cur_duty_nx;
    logic [7:0]          step_cnt, step_cnt_nx;
    logic [7:0]          hold_cnt, hold_cnt_nx;
    logic                mode_q;
    logic                step_due;
    logic                hold_due;

    logic [N_LED-1:0]    led_drive_p1;
    logic                unused_ok;

    assign wr_en     = chipselect && !write_n;
    assign unused_ok = ^{writedata, tick};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_en      <= 1'b0;
            ctrl_mode    <= 1'b0;
            mask         <= '0;
            prescale     <= '0;
            duty         <= '0;
            step_periods <= '0;
            hold_periods <= '0;
        end else if (wr_en) begin
            case (address)
                ADDR_CTRL: begin
                    ctrl_en   <= writedata[CTRL_EN_BIT];
                    ctrl_mode <= writedata[CTRL_MODE_BIT];
                end
                ADDR_MASK:     mask     <= writedata[N_LED-1:0];
                ADDR_PRESCALE: prescale <= writedata[15:0];
                ADDR_DUTY:     duty     <= writedata[PWM_BITS-1:0];
                ADDR_FADE: begin
                    step_periods <= writedata[7:0];
                    hold_periods <= writedata[15:8];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL: begin
                readdata[CTRL_EN_BIT]   = ctrl_en;
                readdata[CTRL_MODE_BIT] = ctrl_mode;
            end
            ADDR_MASK:     readdata[N_LED-1:0]    = mask;
            ADDR_PRESCALE: readdata[15:0]         = prescale;
            ADDR_DUTY:     readdata[PWM_BITS-1:0] = duty;
            ADDR_FADE:     readdata[15:0]         = {hold_periods, step_periods};
            ADDR_STATUS: begin
                readdata[1:0]          = state;
                readdata[8 +: PWM_BITS] = cur_duty;
            end
            default: ;
        endcase
    end

    led_pwm_timebase #(
        .PWM_BITS (PWM_BITS)
    ) u_timebase (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (ctrl_en),
        .prescale   (prescale),
        .tick       (tick),
        .pwm_cnt    (pwm_cnt),
        .period_end (period_end)
    );

    assign step_due = (step_cnt >= eff_periods(step_periods) - 8'd1);
    assign hold_due = (hold_cnt >= eff_periods(hold_periods) - 8'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            cur_duty <= '0;
            step_cnt <= '0;
            hold_cnt <= '0;
            mode_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            cur_duty <= cur_duty_nx;
            step_cnt <= step_cnt_nx;
            hold_cnt <= hold_cnt_nx;
            mode_q   <= ctrl_mode;
        end
    end

    // cur_duty only moves on period_end, so a running pulse is never cut.
    // A mode flip (mode_q lags ctrl_mode by one cycle) sends the FSM back to
    // IDLE but keeps cur_duty until the restart at the next period_end.
    always_comb begin
        state_nx    = state;
        cur_duty_nx = cur_duty;
        step_cnt_nx = step_cnt;
        hold_cnt_nx = hold_cnt;
        if (!ctrl_en) begin
            state_nx    = ST_IDLE;
            cur_duty_nx = '0;
            step_cnt_nx = '0;
            hold_cnt_nx = '0;
        end else if (ctrl_mode != mode_q) begin
            state_nx    = ST_IDLE;
            step_cnt_nx = '0;
            hold_cnt_nx = '0;
        end else if (period_end) begin
            case (state)
                ST_IDLE: begin
                    step_cnt_nx = '0;
                    hold_cnt_nx = '0;
                    if (ctrl_mode) begin
                        state_nx    = ST_UP;
                        cur_duty_nx = '0;
                    end else begin
                        state_nx    = ST_HOLD;
                        cur_duty_nx = duty;
                    end
                end
                ST_UP: begin
                    if (!step_due) begin
                        step_cnt_nx = step_cnt + 8'd1;
                    end else begin
                        step_cnt_nx = '0;
                        // Covers DUTY lowered below cur_duty and DUTY=0.
                        if (cur_duty >= duty) begin
                            cur_duty_nx = duty;
                            state_nx    = ST_HOLD;
                        end else begin
                            cur_duty_nx = cur_duty + PWM_BITS'(1);
                            if (cur_duty + PWM_BITS'(1) == duty)
                                state_nx = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!ctrl_mode) begin
                        cur_duty_nx = duty;
                    end else if (!hold_due) begin
                        hold_cnt_nx = hold_cnt + 8'd1;
                    end else begin
                        hold_cnt_nx = '0;
                        state_nx    = ST_DOWN;
                    end
                end
                ST_DOWN: begin
                    if (!step_due) begin
                        step_cnt_nx = step_cnt + 8'd1;
                    end else begin
                        step_cnt_nx = '0;
                        if (cur_duty <= PWM_BITS'(1)) begin
                            cur_duty_nx = '0;
                            state_nx    = ST_UP;
                        end else begin
                            cur_duty_nx = cur_duty - PWM_BITS'(1);
                        end
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    // Output stage: one register after the counter compare.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_drive_p1 <= '0;
        end else if (!ctrl_en) begin
            led_drive_p1 <= '0;
        end else begin
            led_drive_p1 <= mask & {N_LED{pwm_cnt < cur_duty}};
        end
    end

    assign out_port = led_drive_p1;

endmodule

// File: tb/tb_led_pwm_sequencer.sv
// tb_led_pwm_sequencer
//   Self-checking bench for led_pwm_sequencer. The reference model works
//   per PWM period: the period index and counter value follow directly from
//   the cycle count since enable, and the fade brightness follows from the
//   position inside one triangle of length 2*step*duty + hold periods.
module tb_led_pwm_sequencer;
    import led_pwm_pkg::*;

    localparam int          N_LED    = 26;
    localparam logic [31:0] MASK_ALL = 32'h03FF_FFFF;

    logic              clk        = 1'b0;
    logic              reset_n    = 1'b0;
    logic [2:0]        address    = 3'd0;
    logic              chipselect = 1'b0;
    logic              write_n    = 1'b1;
    logic [31:0]       writedata  = 32'd0;
    logic [31:0]       readdata;
    logic [N_LED-1:0]  out_port;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    led_pwm_sequencer #(
        .N_LED    (N_LED),
        .PWM_BITS (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    // Brightness and state during PWM period n after enable. Period 0 is
    // spent in IDLE; afterwards static mode holds d, fade mode walks the
    // triangle 0..d-1 (UP), d for h periods (HOLD), d..1 (DOWN), repeating.
    task automatic model_period(input int n, input int mode, input int d, input int s,
                                input int h, output int duty, output int st);
        int len, p, q;
        if (n == 0) begin
            duty = 0; st = 0;
        end else if (mode == 0) begin
            duty = d; st = 2;
        end else begin
            len = 2 * s * d + h;
            p   = (n - 1) % len;
            if (p < s * d) begin
                duty = p / s; st = 1;
            end else if (p < s * d + h) begin
                duty = d; st = 2;
            end else begin
                q = p - s * d - h;
                duty = d - q / s; st = 3;
            end
        end
    endtask

    task automatic run_trial(input int mode, input int d, input int s_raw, input int h_raw,
                             input int p, input logic [31:0] mask, input int nper);
        int s, h, ncyc, tk, duty, st;
        logic [31:0] exp_out, exp_stat;
        s = (s_raw == 0) ? 1 : s_raw;
        h = (h_raw == 0) ? 1 : h_raw;
        bus_write(ADDR_CTRL, 32'd0);
        repeat (2) @(negedge clk);
        bus_write(ADDR_MASK, mask);
        bus_write(ADDR_PRESCALE, 32'(p));
        bus_write(ADDR_DUTY, 32'(d));
        bus_write(ADDR_FADE, 32'((h_raw << 8) | s_raw));
        bus_write(ADDR_CTRL, 32'((mode << 1) | 1));
        address = ADDR_STATUS;
        #1;
        ncyc = (p + 1) * 256 * nper;
        for (int c = 0; c < ncyc; c++) begin
            if (c == 0) begin
                exp_out = 32'd0;
            end else begin
                tk = (c - 1) / (p + 1);
                model_period(tk / 256, mode, d, s, h, duty, st);
                exp_out = ((tk % 256) < duty) ? mask : 32'd0;
            end
            check_val($sformatf("out m%0d d%0d c%0d", mode, d, c), 32'(out_port), exp_out);
            tk = c / (p + 1);
            model_period(tk / 256, mode, d, s, h, duty, st);
            exp_stat = 32'((duty << 8) | st);
            check_val($sformatf("status m%0d d%0d c%0d", mode, d, c), readdata, exp_stat);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [31:0] rd, mask;
        int mode, p, d, s, h, hi0, hi1, hi2, last_hi, found;
        logic [31:0] orv;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_out", 32'(out_port), 32'd0);
        reset_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), rd);
            check_val($sformatf("rst_reg%0d", a), rd, 32'd0);
        end

        // Register access and masking of unused bits / addresses
        bus_write(ADDR_CTRL, 32'hFFFF_FFFC);
        bus_read(ADDR_CTRL, rd);      check_val("ctrl_unused", rd, 32'd0);
        bus_write(ADDR_PRESCALE, 32'hABCD_1234);
        bus_read(ADDR_PRESCALE, rd);  check_val("prescale_rb", rd, 32'h0000_1234);
        bus_write(ADDR_FADE, 32'hFFFF_0201);
        bus_read(ADDR_FADE, rd);      check_val("fade_rb", rd, 32'h0000_0201);
        bus_write(ADDR_DUTY, 32'h0000_01FF);
        bus_read(ADDR_DUTY, rd);      check_val("duty_rb", rd, 32'h0000_00FF);
        bus_write(ADDR_MASK, 32'hFFFF_FFFF);
        bus_read(ADDR_MASK, rd);      check_val("mask_rb", rd, MASK_ALL);
        bus_write(3'd6, 32'hFFFF_FFFF);
        bus_read(3'd6, rd);           check_val("addr6", rd, 32'd0);
        bus_write(ADDR_STATUS, 32'hFFFF_FFFF);
        bus_read(ADDR_STATUS, rd);    check_val("status_ro", rd, 32'd0);
        @(negedge clk);
        address = ADDR_DUTY; writedata = 32'h11; chipselect = 1'b0; write_n = 1'b0;
        @(negedge clk);
        write_n = 1'b1;
        bus_read(ADDR_DUTY, rd);      check_val("no_cs_write", rd, 32'h0000_00FF);

        // Fixed fade sequence 0,1,2,3,4,4,4,3,2,1,0,1...
        run_trial(1, 4, 1, 2, 0, MASK_ALL, 12);

        // Randomized static (including duty 0 and 255) and fade trials
        for (int t = 0; t < 6; t++) begin
            mode = t % 2;
            mask = ($urandom & MASK_ALL) | 32'h1;
            if (mode == 0) begin
                p = $urandom_range(0, 2);
                d = (t == 0) ? 0 : (t == 2) ? 255 : $urandom_range(1, 254);
                run_trial(0, d, 0, 0, p, mask, 3);
            end else begin
                p = $urandom_range(0, 1);
                d = $urandom_range(1, 4);
                s = $urandom_range(0, 2);
                h = $urandom_range(0, 3);
                run_trial(1, d, s, h, p, mask,
                          2 * ((s == 0) ? 1 : s) * d + ((h == 0) ? 1 : h) + 2);
            end
        end

        // Mid-period DUTY change 32 -> 200 at pwm_cnt 100
        bus_write(ADDR_CTRL, 32'd0);
        repeat (2) @(negedge clk);
        bus_write(ADDR_MASK, MASK_ALL);
        bus_write(ADDR_PRESCALE, 32'd0);
        bus_write(ADDR_DUTY, 32'd32);
        bus_write(ADDR_CTRL, 32'd1);
        address = ADDR_STATUS;
        #1;
        hi1 = 0; hi2 = 0; last_hi = -1;
        for (int c = 0; c < 770; c++) begin
            if (c >= 257 && c <= 512 && out_port[0]) begin hi1++; last_hi = c - 257; end
            if (c >= 513 && c <= 768 && out_port[0]) hi2++;
            if (c == 356) begin
                address = ADDR_DUTY; writedata = 32'd200; chipselect = 1'b1; write_n = 1'b0;
            end
            if (c == 357) begin
                chipselect = 1'b0; write_n = 1'b1; address = ADDR_STATUS;
            end
            if (c == 400) check_val("mid_duty_old", 32'(readdata[15:8]), 32'd32);
            if (c == 600) check_val("mid_duty_new", 32'(readdata[15:8]), 32'd200);
            @(negedge clk);
        end
        check_val("mid_hi_old", 32'(hi1), 32'd32);
        check_val("mid_last_hi", 32'(last_hi), 32'd31);
        check_val("mid_hi_new", 32'(hi2), 32'd200);

        // Mask 0x5 with duty 64, then disable
        bus_write(ADDR_CTRL, 32'd0);
        repeat (2) @(negedge clk);
        bus_write(ADDR_MASK, 32'h5);
        bus_write(ADDR_DUTY, 32'd64);
        bus_write(ADDR_CTRL, 32'd1);
        address = ADDR_STATUS;
        #1;
        orv = 32'd0; hi0 = 0;
        for (int c = 0; c < 600; c++) begin
            orv = orv | 32'(out_port);
            if (c >= 257 && c <= 512 && out_port[0]) hi0++;
            if (c == 300) check_val("static_status", readdata, 32'h0000_4002);
            @(negedge clk);
        end
        check_val("mask_bits", orv, 32'h5);
        check_val("static_hi64", 32'(hi0), 32'd64);
        bus_write(ADDR_CTRL, 32'd0);
        @(negedge clk);
        address = ADDR_STATUS;
        #1;
        check_val("dis_out", 32'(out_port), 32'd0);
        check_val("dis_status", readdata, 32'd0);

        // Reset asserted during DOWN
        bus_write(ADDR_MASK, MASK_ALL);
        bus_write(ADDR_DUTY, 32'd2);
        bus_write(ADDR_FADE, 32'h0000_0101);
        bus_write(ADDR_CTRL, 32'd3);
        address = ADDR_STATUS;
        found = 0;
        for (int i = 0; i < 4000 && found == 0; i++) begin
            @(negedge clk);
            if (readdata[1:0] == 2'd3 && out_port[0]) found = 1;
        end
        check_val("reach_down", 32'(readdata[1:0]), 32'd3);
        reset_n = 1'b0;
        #1;
        check_val("rst_async_out", 32'(out_port), 32'd0);
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), rd);
            check_val($sformatf("rst_async_reg%0d", a), rd, 32'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;

        // Mode change while enabled returns to IDLE, then restarts in static
        bus_write(ADDR_MASK, MASK_ALL);
        bus_write(ADDR_DUTY, 32'd3);
        bus_write(ADDR_FADE, 32'h0000_0101);
        bus_write(ADDR_CTRL, 32'd3);
        repeat (300) @(negedge clk);
        bus_write(ADDR_CTRL, 32'd1);
        address = ADDR_STATUS;
        @(negedge clk);
        check_val("modechg_idle", 32'(readdata[1:0]), 32'd0);
        found = 0;
        for (int i = 0; i < 600 && found == 0; i++) begin
            @(negedge clk);
            if (readdata[1:0] == 2'd2) found = 1;
        end
        check_val("modechg_hold", readdata, 32'h0000_0302);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_pwm_sequencer.md
LED_PWM_SEQUENCER -- requirements
Module: led_pwm_sequencer

Interface
REQ-001 SHALL have parameter N_LED, default 26, number of LED output channels.
REQ-002 SHALL have parameter PWM_BITS, default 8, width of the duty value and of the PWM counter.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port address  input  3  Avalon-MM word address.
REQ-006 SHALL have port chipselect  input  1  Avalon-MM select.
REQ-007 SHALL have port write_n  input  1  Avalon-MM write strobe, active-low.
REQ-008 SHALL have port writedata  input  32  Avalon-MM write data.
REQ-009 SHALL have port readdata  output  32  Avalon-MM read data, combinational from address, zero wait states.
REQ-010 SHALL have port out_port  output  N_LED  registered PWM drive to the LED PIO pins.

Function
REQ-011 Register map SHALL be: 0 CTRL [0]=enable, [1]=mode (0 static, 1 fade); 1 MASK [N_LED-1:0]; 2 PRESCALE [15:0]; 3 DUTY [7:0], the static duty and the fade peak; 4 FADE [7:0]=step_periods, [15:8]=hold_periods; 5 STATUS, read-only: [1:0]=state, [15:8]=cur_duty.
REQ-012 A register write SHALL occur only when chipselect=1 and write_n=0; unused bits and addresses 6-7 SHALL read 0, and writes to them SHALL be ignored.
REQ-013 Prescaler SHALL count 0..PRESCALE and assert tick for one cycle when count==PRESCALE; PRESCALE=0 SHALL give a tick every cycle.
REQ-014 The PWM counter SHALL increment on tick and wrap from 255 to 0; period_end SHALL be tick while pwm_cnt==255.
REQ-015 out_port[i] SHALL be registered as enable & MASK[i] & (pwm_cnt < cur_duty), with a latency of 1 cycle.
REQ-016 Duty 0 SHALL give a constant low output; duty 255 SHALL give 255 high cycles out of every 256.
REQ-017 cur_duty SHALL change only on period_end, which keeps every pulse glitch-free; a DUTY write mid-period SHALL take effect at the next period_end.
REQ-018 FSM states SHALL be IDLE=0, UP=1, HOLD=2, DOWN=3.
REQ-019 With enable=0, the FSM SHALL be held in IDLE, the prescaler, pwm_cnt, cur_duty and step/hold counters SHALL be cleared, and out_port SHALL be 0 from the next cycle.
REQ-020 With enable=1 and mode=0, the FSM SHALL move IDLE->HOLD and load DUTY into cur_duty at every period_end.
REQ-021 With enable=1 and mode=1, the FSM SHALL move IDLE->UP with cur_duty=0.
REQ-022 In UP, the FSM SHALL add 1 to cur_duty every step_periods period_ends, saturating at DUTY; on reaching DUTY it SHALL go to HOLD.
REQ-023 In HOLD (fade mode), the FSM SHALL wait hold_periods period_ends and then go to DOWN.
REQ-024 In DOWN, the FSM SHALL subtract 1 from cur_duty every step_periods period_ends; on reaching 0 it SHALL go to UP, so the fade repeats continuously.
REQ-025 step_periods=0 and hold_periods=0 SHALL each be treated as 1.
REQ-026 DUTY=0 in fade mode SHALL make UP pass straight to HOLD.
REQ-027 A DUTY write below cur_duty during UP SHALL clamp cur_duty to DUTY at the next step.
REQ-028 A mode change while enable=1 SHALL return the FSM to IDLE at the next cycle, and the FSM SHALL restart from IDLE.
REQ-029 A CTRL write and a period_end in the same cycle SHALL act on the old CTRL for that period_end.

Reset
REQ-030 On reset_n=0, all registers, counters and cur_duty SHALL be cleared to 0, state SHALL be IDLE, and out_port SHALL be 0, asynchronously.
REQ-031 After reset release, the first tick SHALL occur PRESCALE+1 cycles after enable is set.

Structure
REQ-032 Package led_pwm_pkg SHALL hold the state enum, the register address constants, and the CTRL bit positions.
REQ-033 Sub-module led_pwm_timebase SHALL contain the prescaler and the PWM counter and SHALL output tick, pwm_cnt and period_end.

Verification
REQ-034 Static test: PRESCALE=0, DUTY=64, MASK=all ones, enable=1 -> every out_port bit SHALL be high for 64 of every 256 cycles, and STATUS[15:8] SHALL read 64.
REQ-035 Boundary test: DUTY=0, then DUTY=255 -> out_port SHALL be constant 0, then low for exactly 1 cycle per 256.
REQ-036 Fade test: PRESCALE=0, DUTY=4, step=1, hold=2 -> cur_duty sequence per period SHALL be 0,1,2,3,4,4,4,3,2,1,0,1..., and state SHALL be UP->HOLD->DOWN->UP.
REQ-037 Mid-period test: DUTY changed 32->200 at pwm_cnt=100 -> the current pulse SHALL end at count 32, and the next period SHALL give 200 high cycles.
REQ-038 Mask/disable test: MASK=0x0000005, then enable cleared -> only bits 0 and 2 SHALL toggle, and after disable out_port SHALL be 0 one cycle later with STATUS state=IDLE.
REQ-039 Reset test: reset_n asserted during DOWN -> out_port, STATUS and all registers SHALL read 0 immediately.
